// File: rtl/load_ram_pkg.sv
// Shared definitions for the FRAM init-load return path: default widths,
// timeout default and the transfer FSM encoding.
package load_ram_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_LEN_W     = 11;
  localparam int DEF_AF_ADDR_W = 23;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_TMO_CYC   = 255;
  localparam int CONS_ADDR_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter width able to hold the reload value itself.
  function automatic int tmo_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/load_ram_tmo.sv
// Loadable down-counter guarding the wait for a memory read ack.
// expired_o rises in the last permitted wait cycle.
module load_ram_tmo
  import load_ram_pkg::*;
#(
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic clk,
  input  logic srst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = tmo_width(TMO_CYC);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TMO_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with TMO_CYC on entry, so a count of one marks the final wait cycle.
  assign expired_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/load_ram_dist.sv
// FRAM init-load return path: fetches a byte run over a req/ack port and
// strobes each byte to the cons or afpga write port (outputs zero when idle).
module load_ram_dist
  import load_ram_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int AF_ADDR_W = DEF_AF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TMO_CYC   = DEF_TMO_CYC
) (
  input  logic                   sys_clk,
  input  logic                   glbl_rst,
  input  logic                   init_fram_rden,
  input  logic [LEN_W-1:0]       init_fram_length,
  input  logic [ADDR_W-1:0]      init_fram_addr,
  input  logic                   init_dst_sel,
  output logic                   mem_rd_req,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic                   mem_rd_ack,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic                   cons_wren,
  output logic [CONS_ADDR_W-1:0] cons_addr,
  output logic [DATA_W-1:0]      cons_data,
  output logic                   afpga_wren,
  output logic [AF_ADDR_W-1:0]   afpga_addr,
  output logic [DATA_W-1:0]      afpga_wdata,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err
);

  state_t                   state_q;
  logic [LEN_W-1:0]         len_q;
  logic [ADDR_W-1:0]        start_q;
  logic                     dst_q;
  logic [LEN_W-1:0]         idx_q;
  logic [LEN_W-1:0]         idx_d;
  logic [ADDR_W-1:0]        next_addr_d;

  logic                     req_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic                     cons_wren_q;
  logic [CONS_ADDR_W-1:0]   cons_addr_q;
  logic [DATA_W-1:0]        cons_data_q;
  logic                     afpga_wren_q;
  logic [AF_ADDR_W-1:0]     afpga_addr_q;
  logic [DATA_W-1:0]        afpga_wdata_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic                     issue_go;
  logic                     tmo_expired;

  assign idx_d       = idx_q + LEN_W'(1);
  assign next_addr_d = start_q + ADDR_W'(idx_d);

  // The issue step is folded into the edge that leaves IDLE/WRITE, so the
  // registered request is already visible in the following cycle.
  always_comb begin
    issue_go = 1'b0;
    case (state_q)
      S_IDLE:  issue_go = init_fram_rden && (init_fram_length != '0);
      S_ISSUE: issue_go = 1'b1;
      S_WRITE: issue_go = (idx_d < len_q);
      default: issue_go = 1'b0;
    endcase
  end

  load_ram_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk       (sys_clk),
    .srst      (glbl_rst),
    .load_i    (issue_go),
    .en_i      (state_q == S_WAIT),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      start_q       <= '0;
      dst_q         <= 1'b0;
      idx_q         <= '0;
      req_q         <= 1'b0;
      rd_addr_q     <= '0;
      cons_wren_q   <= 1'b0;
      cons_addr_q   <= '0;
      cons_data_q   <= '0;
      afpga_wren_q  <= 1'b0;
      afpga_addr_q  <= '0;
      afpga_wdata_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Strobes and their payloads are single-cycle; zero them by default.
      cons_wren_q   <= 1'b0;
      cons_addr_q   <= '0;
      cons_data_q   <= '0;
      afpga_wren_q  <= 1'b0;
      afpga_addr_q  <= '0;
      afpga_wdata_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (init_fram_rden) begin
            len_q   <= init_fram_length;
            start_q <= init_fram_addr;
            dst_q   <= init_dst_sel;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            if (issue_go) begin
              req_q     <= 1'b1;
              rd_addr_q <= init_fram_addr;
              state_q   <= S_WAIT;
            end else begin
              state_q <= S_DONE;
            end
          end
        end

        S_ISSUE: begin
          req_q     <= 1'b1;
          rd_addr_q <= start_q + ADDR_W'(idx_q);
          state_q   <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_rd_ack) begin
            req_q     <= 1'b0;
            rd_addr_q <= '0;
            if (dst_q) begin
              afpga_wren_q  <= 1'b1;
              afpga_addr_q  <= AF_ADDR_W'(idx_q);
              afpga_wdata_q <= mem_rd_data;
            end else begin
              cons_wren_q <= 1'b1;
              cons_addr_q <= CONS_ADDR_W'(idx_q);
              cons_data_q <= mem_rd_data;
            end
            state_q <= S_WRITE;
          end else if (tmo_expired) begin
            req_q     <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        S_WRITE: begin
          idx_q <= idx_d;
          if (issue_go) begin
            req_q     <= 1'b1;
            rd_addr_q <= next_addr_d;
            state_q   <= S_WAIT;
          end else begin
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // A request arriving while a transfer owns the engine is refused.
      if (init_fram_rden && (state_q != S_IDLE)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_rd_addr = rd_addr_q;
  assign cons_wren   = cons_wren_q;
  assign cons_addr   = cons_addr_q;
  assign cons_data   = cons_data_q;
  assign afpga_wren  = afpga_wren_q;
  assign afpga_addr  = afpga_addr_q;
  assign afpga_wdata = afpga_wdata_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule
